bus_arbiter_8: RTL and testbench

BUS_ARBITER_8 -- requirements
Module: bus_arbiter_8

---
 rtl/bus_arbiter_8.sv | 144 ++++++++++++++
 tb/tb_bus_arbiter_8.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_8.sv
// bus_arbiter_8: eight-source round-robin arbiter with a per-grant burst limit.
//
// A two-state FSM (idle / grant) picks one requester, starting the search at a
// rotating pointer. The chosen word is steered onto y through a bit-sliced
// 32-bit 8:1 mux. The grant is held for up to MAX_HOLD transfers. It rotates
// early if the owner withdraws its request.
//
// Ports
//   clk        in   1   single clock, rising edge
//   reset      in   1   synchronous, active-high
//   req        in   8   per-requester request, bit i = source i
//   op0..op7   in  32   per-requester data word
//   out_ready  in   1   consumer accepts y this cycle
//   y          out 32   data word of the selected requester
//   out_valid  out  1   y holds a valid granted word
//   gnt        out  8   registered one-hot grant, zero when idle
//   ack        out  8   one-hot pulse to the requester whose word transferred
//   s2,s1,s0   out  1   registered binary select of the granted requester

module bus_arbiter_8 #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  req,
    input  logic [31:0] op0,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic [31:0] op3,
    input  logic [31:0] op4,
    input  logic [31:0] op5,
    input  logic [31:0] op6,
    input  logic [31:0] op7,
    input  logic        out_ready,
    output logic [31:0] y,
    output logic        out_valid,
    output logic [7:0]  gnt,
    output logic [7:0]  ack,
    output logic        s2,
    output logic        s1,
    output logic        s0
);

    localparam logic [4:0] MaxHold = 5'(MAX_HOLD);

    typedef enum logic {StIdle, StGrant} state_e;

    state_e      state_q;
    logic [7:0]  gnt_q;
    logic [2:0]  sel_q;
    logic [2:0]  ptr_q;
    logic [3:0]  hold_q;

    // First set bit of r searching start, start+1, ... start+7 (mod 8).
    // The loop runs backwards so the smallest offset is assigned last and wins.
    function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] start);
        logic [2:0] idx;
        rr_pick = start;
        for (int k = 7; k >= 0; k--) begin
            idx = start + 3'(k);
            if (r[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

    logic [7:0] sel_oh;
    logic [2:0] sel_next;
    logic [7:0] rearb_req;
    logic [2:0] idle_pick;
    logic [2:0] rearb_pick;
    logic       in_grant;
    logic       xfer;
    logic       last_xfer;
    logic       rotate;

    assign in_grant   = (state_q == StGrant);
    assign sel_oh     = 8'b1 << sel_q;
    assign sel_next   = sel_q + 3'd1;
    // The current owner is excluded when the grant is forced to move on.
    assign rearb_req  = req & ~sel_oh;
    assign idle_pick  = rr_pick(req, ptr_q);
    assign rearb_pick = rr_pick(rearb_req, sel_next);

    // Reset masks the handshake so an aborted grant never pulses ack.
    assign out_valid  = ~reset & in_grant & req[sel_q];
    assign xfer       = out_valid & out_ready;
    assign ack        = xfer ? sel_oh : 8'h00;

    assign last_xfer  = xfer & (({1'b0, hold_q} + 5'd1) >= MaxHold);
    assign rotate     = in_grant & (~req[sel_q] | last_xfer);

    assign gnt          = gnt_q;
    assign {s2, s1, s0} = sel_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            gnt_q   <= 8'h00;
            sel_q   <= 3'd0;
            ptr_q   <= 3'd0;
            hold_q  <= 4'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (|req) begin
                        state_q <= StGrant;
                        gnt_q   <= 8'b1 << idle_pick;
                        sel_q   <= idle_pick;
                        hold_q  <= 4'd0;
                    end
                end
                StGrant: begin
                    if (rotate) begin
                        ptr_q  <= sel_next;
                        hold_q <= 4'd0;
                        if (|rearb_req) begin
                            // Hand over directly, no idle bubble.
                            gnt_q <= 8'b1 << rearb_pick;
                            sel_q <= rearb_pick;
                        end else begin
                            state_q <= StIdle;
                            gnt_q   <= 8'h00;
                        end
                    end else if (xfer) begin
                        hold_q <= hold_q + 4'd1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    gnt_q   <= 8'h00;
                end
            endcase
        end
    end

    // Bit-sliced 32-bit 8:1 mux: each output bit picks its column by {s2,s1,s0}.
    for (genvar b = 0; b < 32; b++) begin : g_mux
        logic [7:0] col;
        assign col  = {op7[b], op6[b], op5[b], op4[b], op3[b], op2[b], op1[b], op0[b]};
        assign y[b] = col[{s2, s1, s0}];
    end

endmodule

// File: tb/tb_bus_arbiter_8.sv
// Scoreboard bench for bus_arbiter_8. The stimulus process drives one cycle
// at a time and runs a behavioural model of the arbitration rules, pushing the
// expected outputs for that cycle. A separate monitor pops the expectations
// and compares them against the DUT outputs, sampled at the falling edge.

module tb_bus_arbiter_8;

    localparam int MaxHold = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  req = 8'h00;
    logic [31:0] op [8];
    logic        out_ready = 1'b0;
    logic [31:0] y;
    logic        out_valid;
    logic [7:0]  gnt;
    logic [7:0]  ack;
    logic        s2, s1, s0;

    always #5 clk = ~clk;

    bus_arbiter_8 #(
        .MAX_HOLD (MaxHold)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .op0       (op[0]),
        .op1       (op[1]),
        .op2       (op[2]),
        .op3       (op[3]),
        .op4       (op[4]),
        .op5       (op[5]),
        .op6       (op[6]),
        .op7       (op[7]),
        .out_ready (out_ready),
        .y         (y),
        .out_valid (out_valid),
        .gnt       (gnt),
        .ack       (ack),
        .s2        (s2),
        .s1        (s1),
        .s0        (s0)
    );

    typedef struct {
        logic [7:0]  gnt;
        logic        valid;
        logic [7:0]  ack;
        logic [31:0] y;
        logic        chk_sel;
        logic [2:0]  sel;
    } exp_t;

    exp_t sb [$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model state: owner = -1 means nobody holds the bus.
    int owner = -1;
    int ptr = 0;
    int cnt = 0;
    int msel = 0;
    bit known = 1'b1;

    bit          use_next_op2 = 1'b0;
    logic [31:0] next_op2 = 32'h0;

    function automatic int first_from(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++) begin
            int i;
            i = (p + k) % 8;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    // Drive one cycle of stimulus, record the expected outputs, advance the model.
    task automatic apply(input logic rst, input logic [7:0] r, input logic rdy,
                         input bit hold_ops);
        exp_t       e;
        bit         xfer;
        bit         done;
        int         w;
        logic [7:0] m;
        @(posedge clk);
        #1;
        reset     = rst;
        req       = r;
        out_ready = rdy;
        if (!hold_ops) begin
            for (int k = 0; k < 8; k++) op[k] = $urandom;
        end
        if (use_next_op2) op[2] = next_op2;

        e.gnt   = (owner >= 0) ? 8'(1 << owner) : 8'h00;
        e.valid = 1'b0;
        if (!rst && owner >= 0) e.valid = r[owner];
        xfer    = e.valid && rdy;
        e.ack   = xfer ? 8'(1 << owner) : 8'h00;
        e.y     = (owner >= 0) ? op[owner] : 32'h0;
        e.chk_sel = known;
        e.sel   = 3'(msel);
        sb.push_back(e);

        if (rst) begin
            owner = -1; ptr = 0; cnt = 0; msel = 0; known = 1'b1;
        end else if (owner < 0) begin
            w = first_from(r, ptr);
            if (w >= 0) begin
                owner = w; msel = w; known = 1'b1; cnt = 0;
            end
        end else begin
            done = !r[owner] || (xfer && (cnt + 1 >= MaxHold));
            if (done) begin
                ptr = (owner + 1) % 8;
                m = r;
                m[owner] = 1'b0;
                w = first_from(m, ptr);
                cnt = 0;
                if (w >= 0) begin
                    owner = w; msel = w;
                end else begin
                    owner = -1; known = 1'b0;
                end
            end else if (xfer) begin
                cnt++;
            end
        end
    endtask

    // Monitor: one expectation per cycle, compared away from the rising edge.
    initial begin
        exp_t e;
        bit   bad;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                vectors++;
                bad = 1'b0;
                if (gnt !== e.gnt) begin
                    $display("FAIL gnt vec %0d: got %h expected %h", vectors, gnt, e.gnt);
                    bad = 1'b1;
                end
                if (out_valid !== e.valid) begin
                    $display("FAIL out_valid vec %0d: got %b expected %b", vectors,
                             out_valid, e.valid);
                    bad = 1'b1;
                end
                if (ack !== e.ack) begin
                    $display("FAIL ack vec %0d: got %h expected %h", vectors, ack, e.ack);
                    bad = 1'b1;
                end
                if (e.valid && (y !== e.y)) begin
                    $display("FAIL y vec %0d: got %h expected %h", vectors, y, e.y);
                    bad = 1'b1;
                end
                if (e.chk_sel && ({s2, s1, s0} !== e.sel)) begin
                    $display("FAIL sel vec %0d: got %0d expected %0d", vectors,
                             {s2, s1, s0}, e.sel);
                    bad = 1'b1;
                end
                if (bad) miscompares++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r;
        for (int k = 0; k < 8; k++) op[k] = 32'h0;
        reset = 1'b1;
        @(posedge clk);

        // Reset with random requests present: they must be ignored.
        apply(1'b1, 8'($urandom), 1'b1, 1'b0);
        apply(1'b1, 8'($urandom), 1'b1, 1'b0);

        // Single requester, one-cycle latency, known data word.
        use_next_op2 = 1'b1;
        next_op2     = 32'hDEADBEEF;
        apply(1'b0, 8'h04, 1'b1, 1'b0);
        apply(1'b0, 8'h04, 1'b1, 1'b0);
        use_next_op2 = 1'b0;
        repeat (3) apply(1'b0, 8'h00, 1'b1, 1'b0);

        // Burst limit between two requesters.
        repeat (20) apply(1'b0, 8'h03, 1'b1, 1'b0);

        // All requesting: rotation through every source, including wrap 7 -> 0.
        repeat (40) apply(1'b0, 8'hFF, 1'b1, 1'b0);
        repeat (2) apply(1'b0, 8'h00, 1'b1, 1'b0);

        // Stall on requester 5 with stable data, then release.
        apply(1'b0, 8'h20, 1'b0, 1'b0);
        repeat (3) apply(1'b0, 8'h20, 1'b0, 1'b1);
        apply(1'b0, 8'h20, 1'b1, 1'b1);
        repeat (2) apply(1'b0, 8'h00, 1'b1, 1'b0);

        // Withdrawal by requester 7 while requester 0 rises.
        apply(1'b0, 8'h80, 1'b0, 1'b0);
        apply(1'b0, 8'h80, 1'b0, 1'b0);
        apply(1'b0, 8'h01, 1'b0, 1'b0);
        apply(1'b0, 8'h01, 1'b1, 1'b0);
        apply(1'b0, 8'h00, 1'b1, 1'b0);

        // Reset in the middle of a burst, then pointer restarts at 0.
        repeat (3) apply(1'b0, 8'h03, 1'b1, 1'b0);
        apply(1'b1, 8'h03, 1'b1, 1'b0);
        repeat (3) apply(1'b0, 8'h81, 1'b1, 1'b0);

        // Randomized traffic.
        repeat (600) begin
            if ($urandom_range(0, 2) == 0) r = 8'($urandom);
            else if ($urandom_range(0, 1) == 0) r = 8'(1 << $urandom_range(0, 7));
            else r = 8'(1 << $urandom_range(0, 7)) | 8'(1 << $urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) r = 8'h00;
            apply(($urandom_range(0, 63) == 0), r, ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) == 0));
        end

        @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
